// File: rtl/repl_policy_unit.sv
// Per-set replacement-policy engine for the N-way caches.
// Keeps per-set replacement state (tree-PLRU, MRU or FIFO), or a free-running
// LFSR for random replacement, and answers victim requests one cycle later.
// A flush walks every set once and clears its state.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | normal operation: hits, fills and victim requests accepted
//   ST_FLUSH | clearing one set per cycle; hits, fills and requests ignored
module repl_policy_unit #(
  parameter int unsigned SETS      = 128,
  parameter int unsigned WAYS      = 4,
  parameter int unsigned POLICY    = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [$clog2(SETS)-1:0]   access_set_i,
  input  logic [WAYS-1:0]           way_valid_i,
  input  logic                      hit_i,
  input  logic [$clog2(WAYS)-1:0]   hit_way_i,
  input  logic                      fill_i,
  input  logic [$clog2(SETS)-1:0]   fill_set_i,
  input  logic [$clog2(WAYS)-1:0]   fill_way_i,
  input  logic                      victim_req_i,
  output logic                      victim_vld_o,
  output logic [$clog2(WAYS)-1:0]   victim_way_o,
  input  logic                      flush_i,
  output logic                      busy_o
);

  localparam int SW   = $clog2(SETS);
  localparam int WW   = $clog2(WAYS);
  // PLRU needs WAYS-1 tree bits; MRU and FIFO need one way index.
  localparam int ST_W = (POLICY == 0) ? int'(WAYS) - 1 : WW;

  typedef enum logic {ST_IDLE, ST_FLUSH} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   flush_set_q, flush_set_d;
  logic            busy;
  logic            req_en;
  logic [WW-1:0]   pol_victim;
  logic [WW-1:0]   inv_way;
  logic            any_inv;

  assign busy   = (state_q == ST_FLUSH);
  assign busy_o = busy;
  assign req_en = victim_req_i & ~busy;

  // New per-set state after touching 'way'; FIFO only advances on fills.
  function automatic logic [ST_W-1:0] touch(input logic [ST_W-1:0] st,
                                            input logic [WW-1:0]   way,
                                            input logic            is_fill);
    logic [ST_W-1:0] r;
    logic [WW-1:0]   w;
    int              node;
    logic            dir;
    r    = st;
    w    = way;
    node = 0;
    dir  = 1'b0;
    case (POLICY)
      0: begin
        // Each node on the path points away from the touched way.
        for (int l = 0; l < WW; l++) begin
          dir = w[WW-1];
          r[node[WW-1:0]] = ~dir;
          node = 2 * node + 1 + int'(dir);
          w = w << 1;
        end
      end
      1:       r = ST_W'(way);
      2:       if (is_fill) r = st + ST_W'(1);
      default: r = st;
    endcase
    return r;
  endfunction

  // Victim way implied by one set's replacement state.
  function automatic logic [WW-1:0] victim_of(input logic [ST_W-1:0] st);
    logic [WW-1:0] v;
    int            node;
    logic          dir;
    v    = '0;
    node = 0;
    dir  = 1'b0;
    case (POLICY)
      0: begin
        for (int l = 0; l < WW; l++) begin
          dir = st[node[WW-1:0]];
          v = (v << 1) | WW'(dir);
          node = 2 * node + 1 + int'(dir);
        end
      end
      1:       v = (st[WW-1:0] == '0) ? WW'(1) : '0;
      2:       v = st[WW-1:0];
      default: v = '0;
    endcase
    return v;
  endfunction

  // Flush walk state and set counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      flush_set_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_set_q <= flush_set_d;
    end
  end

  // Flush walk next state: a new flush_i always restarts from set 0.
  always_comb begin
    state_d     = state_q;
    flush_set_d = flush_set_q;
    case (state_q)
      ST_IDLE: begin
        if (flush_i) begin
          state_d     = ST_FLUSH;
          flush_set_d = '0;
        end
      end
      ST_FLUSH: begin
        if (flush_i) begin
          flush_set_d = '0;
        end else if (flush_set_q == SW'(SETS - 1)) begin
          state_d     = ST_IDLE;
          flush_set_d = '0;
        end else begin
          flush_set_d = flush_set_q + SW'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        flush_set_d = '0;
      end
    endcase
  end

  generate
    if (POLICY == 3) begin : g_random
      logic [15:0] lfsr_q;

      // Galois LFSR, x^16+x^14+x^13+x^11, free-running out of reset.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      end

      assign pol_victim = lfsr_q[WW-1:0];
    end else begin : g_state
      logic [ST_W-1:0] st_q [SETS];
      logic [ST_W-1:0] st_acc, st_fill;
      logic [ST_W-1:0] hit_next, fill_next;

      assign st_acc     = st_q[access_set_i];
      assign st_fill    = st_q[fill_set_i];
      assign hit_next   = touch(st_acc, hit_way_i, 1'b0);
      assign fill_next  = touch(st_fill, fill_way_i, 1'b1);
      assign pol_victim = victim_of(st_acc);

      // Per-set state: flush clears, else hit then fill (fill wins on the same set).
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int s = 0; s < int'(SETS); s++) st_q[s] <= '0;
        end else if (busy) begin
          st_q[flush_set_q] <= '0;
        end else begin
          if (hit_i)  st_q[access_set_i] <= hit_next;
          if (fill_i) st_q[fill_set_i]   <= fill_next;
        end
      end
    end
  endgenerate

  // Lowest-index invalid way overrides the policy choice.
  always_comb begin
    inv_way = '0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (!way_valid_i[i]) inv_way = WW'(i);
    end
  end

  assign any_inv = ~&way_valid_i;

  // Registered victim response; the way holds between responses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      victim_vld_o <= 1'b0;
      victim_way_o <= '0;
    end else begin
      victim_vld_o <= req_en;
      if (req_en) victim_way_o <= any_inv ? inv_way : pol_victim;
    end
  end

endmodule

// File: tb/tb_repl_policy_unit.sv
// Directed bench: one DUT per policy, all driven by the same stimulus.
module tb_repl_policy_unit;
  localparam int SETS = 16;
  localparam int WAYS = 4;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] access_set_i = '0;
  logic [3:0] way_valid_i  = '1;
  logic       hit_i        = 1'b0;
  logic [1:0] hit_way_i    = '0;
  logic       fill_i       = 1'b0;
  logic [3:0] fill_set_i   = '0;
  logic [1:0] fill_way_i   = '0;
  logic       victim_req_i = 1'b0;
  logic       flush_i      = 1'b0;

  logic [3:0] vld;
  logic [3:0] busy;
  logic [1:0] way [4];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_i = ~clk_i;

  for (genvar p = 0; p < 4; p++) begin : g_dut
    repl_policy_unit #(
      .SETS(SETS), .WAYS(WAYS), .POLICY(p), .LFSR_SEED(16'hACE1)
    ) u_dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .access_set_i(access_set_i), .way_valid_i(way_valid_i),
      .hit_i(hit_i), .hit_way_i(hit_way_i),
      .fill_i(fill_i), .fill_set_i(fill_set_i), .fill_way_i(fill_way_i),
      .victim_req_i(victim_req_i),
      .victim_vld_o(vld[p]), .victim_way_o(way[p]),
      .flush_i(flush_i), .busy_o(busy[p])
    );
  end

  // Reference LFSR: x^16+x^14+x^13+x^11, Galois form, seed ACE1.
  logic [15:0] lfsr_m;
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_m <= 16'hACE1;
    else       lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic hit_t(input int set, input int w);
    hit_i = 1'b1; access_set_i = 4'(set); hit_way_i = 2'(w);
    tick();
    hit_i = 1'b0;
  endtask

  task automatic fill_t(input int set, input int w);
    fill_i = 1'b1; fill_set_i = 4'(set); fill_way_i = 2'(w);
    tick();
    fill_i = 1'b0;
  endtask

  task automatic both_t(input int hset, input int hw, input int fset, input int fw);
    hit_i = 1'b1; access_set_i = 4'(hset); hit_way_i = 2'(hw);
    fill_i = 1'b1; fill_set_i = 4'(fset); fill_way_i = 2'(fw);
    tick();
    hit_i = 1'b0; fill_i = 1'b0;
  endtask

  task automatic req(input int p, input int set, input logic [3:0] valid,
                     input int exp, input string tag);
    victim_req_i = 1'b1; access_set_i = 4'(set); way_valid_i = valid;
    tick();
    victim_req_i = 1'b0; way_valid_i = 4'hF;
    chk({tag, "_vld"}, int'(vld[p]), 1);
    chk(tag, int'(way[p]), exp);
  endtask

  initial begin
    int cnt;
    int bad;
    int exp_r;

    #12 rst_i = 1'b0;
    tick();
    chk("rst_vld", int'(vld[0]), 0);
    chk("rst_way", int'(way[0]), 0);
    chk("rst_busy", int'(busy[0]), 0);

    // Tree-PLRU on set 3.
    req(0, 3, 4'hF, 0, "plru_init");
    hit_t(3, 0);
    req(0, 3, 4'hF, 2, "plru_t0");
    fill_t(3, 2);
    req(0, 3, 4'hF, 1, "plru_t2");
    hit_t(3, 1);
    req(0, 3, 4'hF, 3, "plru_t1");
    tick();
    chk("vld_pulse", int'(vld[0]), 0);
    chk("way_hold", int'(way[0]), 3);

    // MRU on set 2.
    req(1, 2, 4'hF, 1, "mru_init");
    hit_t(2, 0);
    req(1, 2, 4'hF, 1, "mru_h0");
    hit_t(2, 1);
    req(1, 2, 4'hF, 0, "mru_h1");
    fill_t(2, 3);
    req(1, 2, 4'hF, 0, "mru_f3");

    // FIFO on set 5 with a hit between every fill.
    for (int i = 0; i < 5; i++) begin
      fill_t(5, i % 4);
      hit_t(5, 3);
      req(2, 5, 4'hF, (i + 1) % 4, "fifo_ptr");
    end
    req(2, 6, 4'hF, 0, "fifo_other_set");

    // Invalid-way priority on every policy.
    for (int p = 0; p < 4; p++) begin
      req(p, 3, 4'b1011, 2, "inv_1011");
      req(p, 3, 4'b0000, 0, "inv_0000");
    end
    req(0, 3, 4'b0111, 3, "inv_0111");

    // Back-to-back requests on PLRU.
    victim_req_i = 1'b1; access_set_i = 4'd7;
    tick();
    chk("b2b_first_vld", int'(vld[0]), 1);
    chk("b2b_first_way", int'(way[0]), 0);
    access_set_i = 4'd3;
    tick();
    victim_req_i = 1'b0;
    chk("b2b_second_vld", int'(vld[0]), 1);
    chk("b2b_second_way", int'(way[0]), 3);

    // MRU hit/fill collisions.
    both_t(9, 1, 9, 0);
    req(1, 9, 4'hF, 1, "coll_fill_wins");
    both_t(9, 1, 9, 2);
    req(1, 9, 4'hF, 0, "coll_mru2");
    both_t(10, 2, 11, 3);
    req(1, 10, 4'hF, 0, "diff_set_hit");
    req(1, 11, 4'hF, 0, "diff_set_fill");

    // RANDOM against the reference LFSR, with varying gaps.
    for (int k = 0; k < 6; k++) begin
      for (int g = 0; g < k; g++) tick();
      exp_r = int'(lfsr_m[1:0]);
      req(3, k, 4'hF, exp_r, "rand");
    end

    // Flush with a same-cycle request, then requests and hits while busy.
    flush_i = 1'b1; victim_req_i = 1'b1; access_set_i = 4'd3;
    tick();
    flush_i = 1'b0; victim_req_i = 1'b0;
    chk("flush_req_vld", int'(vld[0]), 1);
    chk("flush_req_way", int'(way[0]), 3);
    chk("flush_busy", int'(busy[0]), 1);
    cnt = 0;
    bad = 0;
    while (busy[0] && cnt < 4 * SETS) begin
      cnt++;
      victim_req_i = 1'b1; hit_i = 1'b1; access_set_i = 4'd3; hit_way_i = 2'd0;
      tick();
      if (vld[0] || vld[1]) bad++;
    end
    victim_req_i = 1'b0; hit_i = 1'b0;
    chk("flush_len", cnt, SETS);
    chk("busy_no_vld", bad, 0);
    req(0, 3, 4'hF, 0, "post_flush_plru");
    req(1, 9, 4'hF, 1, "post_flush_mru");
    req(2, 5, 4'hF, 0, "post_flush_fifo");

    // Flush restarted during the fourth busy cycle.
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    cnt = 0;
    while (busy[0] && cnt < 4 * SETS) begin
      cnt++;
      flush_i = (cnt == 4);
      tick();
    end
    flush_i = 1'b0;
    chk("flush_restart_len", cnt, 4 + SETS);

    // Reset in the middle of a walk.
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    tick();
    tick();
    chk("mid_flush_busy", int'(busy[0]), 1);
    rst_i = 1'b1;
    #1;
    chk("rst_abort_busy", int'(busy[0]), 0);
    rst_i = 1'b0;
    tick();
    chk("rst_abort_stays", int'(busy[0]), 0);
    req(3, 0, 4'hF, int'(lfsr_m[1:0]), "rand_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1);
  end
endmodule
